// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequenced ALU controller.
// Opcodes, FSM states and the default word width.
package alu_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_MUL = 4'd6,
        OP_DIV = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_iter.sv
// One-bit-per-step datapath: shift-add multiply, restoring divide.
// hi:lo holds the running product or remainder:quotient.
module mul_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] den_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, den_q} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, den_q};
        hi_d     = add_sum[WIDTH:1];
        lo_d     = {add_sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            // bit WIDTH of the difference is the borrow
            if (!rem_diff[WIDTH]) begin
                hi_d = rem_diff[WIDTH-1:0];
                lo_d = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            den_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            den_q <= op_b;
            hi    <= '0;
            lo    <= op_a;
        end else if (step) begin
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU: single-cycle logic/arith ops plus
// WIDTH-step iterative MUL/DIV through mul_div_iter.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] rb,
    input  logic [WIDTH-1:0] ry,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             iter_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             dz_q;

    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_dz;
    logic             iter_req;
    logic             load;
    logic             step;
    logic             last;
    logic             sel_dp;
    logic [WIDTH-1:0] dp_hi;
    logic [WIDTH-1:0] dp_lo;

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_dz    = 1'b0;
        iter_req = 1'b0;
        case (opcode)
            OP_AND: sc_lo = rb & ry;
            OP_OR:  sc_lo = rb | ry;
            OP_ADD: sc_lo = rb + ry;
            OP_SUB: sc_lo = rb - ry;
            OP_SHL: sc_lo = rb << ry[4:0];
            OP_SHR: sc_lo = rb >> ry[4:0];
            OP_MUL: iter_req = 1'b1;
            OP_DIV: begin
                if (ry == '0) begin
                    sc_lo = '1;
                    sc_hi = rb;
                    sc_dz = 1'b1;
                end else begin
                    iter_req = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = iter_req;
                    state_d = iter_req ? ST_ITER : ST_DONE;
                end
            end
            ST_ITER: begin
                step = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            iter_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        div_q  <= (opcode == OP_DIV);
                        iter_q <= iter_req;
                        cnt_q  <= '0;
                        if (!iter_req) begin
                            res_lo_q <= sc_lo;
                            res_hi_q <= sc_hi;
                            dz_q     <= sc_dz;
                        end
                    end
                end
                ST_ITER: cnt_q <= last ? '0 : cnt_q + 1'b1;
                ST_DONE: begin
                    // capture iterative result so it survives the next load
                    if (iter_q) begin
                        res_lo_q <= dp_lo;
                        res_hi_q <= dp_hi;
                        dz_q     <= 1'b0;
                        iter_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    mul_div_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .step   (step),
        .is_div (div_q),
        .op_a   (rb),
        .op_b   (ry),
        .hi     (dp_hi),
        .lo     (dp_lo)
    );

    assign ready       = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign sel_dp      = done && iter_q;
    assign result_lo   = sel_dp ? dp_lo : res_lo_q;
    assign result_hi   = sel_dp ? dp_hi : res_hi_q;
    assign div_by_zero = !sel_dp && dz_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: vector table, scoreboard on done,
// and hand sequences for ignored start and mid-op reset.
module tb_alu_seq_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] rb = '0;
    logic [W-1:0] ry = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .rb         (rb),
        .ry         (ry),
        .ready      (ready),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } res_t;

    res_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] lo,
                                input logic [W-1:0] hi, input logic dz,
                                input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.lo = lo; v.hi = hi; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        vec_t v;
        logic [2*W-1:0] p;
        v = mk(op, a, b, '0, '0, 1'b0, 1);
        case (op)
            4'd0: v.lo = a & b;
            4'd1: v.lo = a | b;
            4'd2: v.lo = a + b;
            4'd3: v.lo = a - b;
            4'd4: v.lo = a << b[4:0];
            4'd5: v.lo = a >> b[4:0];
            4'd6: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                v.hi = p[2*W-1:W];
                v.lo = p[W-1:0];
                v.lat = W + 1;
            end
            4'd7: begin
                if (b == '0) begin
                    v.lo = '1; v.hi = a; v.dz = 1'b1;
                end else begin
                    v.lo = a / b; v.hi = a % b; v.lat = W + 1;
                end
            end
            default: ;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 96'(sb_q.size()), 96'd1);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("result", 96'({result_hi, result_lo, div_by_zero}),
                    96'({e.hi, e.lo, e.dz}));
            end
        end
    end

    // Entered and left at a negedge in IDLE, so consecutive calls are back-to-back.
    task automatic run_op(input vec_t v, input int poke);
        res_t e;
        int   cyc;
        logic busy_rdy;
        chk("ready_idle", 96'(ready), 96'd1);
        opcode = v.op; rb = v.a; ry = v.b; start = 1'b1;
        e.lo = v.lo; e.hi = v.hi; e.dz = v.dz;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        opcode = 4'($urandom); rb = $urandom; ry = $urandom;
        cyc = 0;
        busy_rdy = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && ready) busy_rdy = 1'b1;
            if (poke != 0 && cyc == poke) begin
                start = 1'b1; opcode = OP_ADD;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 100);
        chk("latency", 96'(cyc), 96'(v.lat));
        if (v.lat > 1) chk("ready_busy", 96'(busy_rdy), 96'd0);
        @(negedge clk);
        chk("hold", 96'({done, result_hi, result_lo, div_by_zero}),
            96'({1'b0, e.hi, e.lo, e.dz}));
    endtask

    vec_t tbl[15];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 1);
        tbl[1]  = mk(4'd1, 32'h0F0F0000, 32'h00F0F0F0, 32'h0FFFF0F0, 0, 0, 1);
        tbl[2]  = mk(4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0, 0, 1);
        tbl[3]  = mk(4'd3, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0, 1);
        tbl[4]  = mk(4'd4, 32'd1, 32'd31, 32'h80000000, 0, 0, 1);
        tbl[5]  = mk(4'd5, 32'h80000000, 32'h00000024, 32'h08000000, 0, 0, 1);
        tbl[6]  = mk(4'd6, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 33);
        tbl[7]  = mk(4'd7, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33);
        tbl[8]  = mk(4'd7, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 1);
        tbl[9]  = mk(4'd12, 32'd1234, 32'd5, 0, 0, 0, 1);
        tbl[10] = mk(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 33);
        tbl[11] = mk(4'd7, 32'd3, 32'd10, 32'd0, 32'd3, 0, 33);
        tbl[12] = mk(4'd7, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 33);
        tbl[13] = mk(4'd6, 32'd0, 32'h12345678, 32'd0, 32'd0, 0, 33);
        tbl[14] = mk(4'd15, 32'hDEADBEEF, 32'h1, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        chk("rst_ready", 96'(ready), 96'd1);
        chk("rst_out", 96'({done, result_hi, result_lo, div_by_zero}), 96'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) run_op(tbl[i], 0);

        // ADD pulsed mid-MUL must not be queued or executed
        run_op(model(4'd6, 32'h12345678, 32'h9), 5);

        // reset in the tenth ITER cycle of a DIV
        opcode = OP_DIV; rb = 32'd100; ry = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ready", 96'(ready), 96'd1);
        chk("rst_mid_out", 96'({done, result_hi, result_lo, div_by_zero}), 96'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", 96'(done), 96'd0);
        end
        reset_n = 1'b1;
        run_op(mk(4'd3, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0, 1), 0);
        run_op(mk(4'd4, 32'd1, 32'd31, 32'h80000000, 0, 0, 1), 0);
        run_op(mk(4'd12, 32'hFFFF, 32'hFFFF, 0, 0, 0, 1), 0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            run_op(model(op, a, b), 0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 96'(sb_q.size()), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
